// File: rtl/serial_add_seq_if.sv
// Request/response bundle for the bit-serial adder: operands and start in, busy/done/result out.
interface serial_add_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, op_a, op_b,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: LSB-first through a 1-bit full add with registered carry.
// done pulses WIDTH+1 cycles after an accepted start; start is ignored while busy or done.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_add_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] ps_q, ps_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cy_q, cy_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic bit_s;
    logic bit_c;

    // The single-bit full-add cell fed by the shift registers.
    assign bit_s = sa_q[0] ^ sb_q[0] ^ cy_q;
    assign bit_c = (sa_q[0] & sb_q[0]) | (sa_q[0] & cy_q) | (sb_q[0] & cy_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            ps_q    <= '0;
            sum_q   <= '0;
            cy_q    <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ps_q    <= ps_d;
            sum_q   <= sum_d;
            cy_q    <= cy_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ps_d    = ps_q;
        sum_d   = sum_q;
        cy_d    = cy_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.op_a;
                    sb_d    = bus.op_b;
                    cy_d    = 1'b0;
                    cnt_d   = '0;
                    ps_d    = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                cy_d  = bit_c;
                ps_d  = {bit_s, ps_q[WIDTH-1:1]};
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                // Last bit: publish the assembled word and its carry-out together.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {bit_s, ps_q[WIDTH-1:1]};
                    cout_d  = bit_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_seq.sv
// Randomised and directed checks of serial_add_seq against an arithmetic reference with a result scoreboard.
module tb_serial_add_seq;
    localparam int W = 8;

    logic clk;
    logic rst;

    serial_add_seq_if #(.WIDTH(W)) ifc ();

    serial_add_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [W-1:0] s;
        logic         c;
    } exp_t;

    exp_t sbq[$];

    int errors = 0;
    int checks = 0;

    // Reference timeline, counted in rising edges since time zero.
    int ecnt      = 0;
    int acc_edge  = -100;
    int done_edge = -100;
    int next_ok   = 0;
    logic [W-1:0] pend_sum  = '0;
    logic         pend_cout = 1'b0;
    logic [W-1:0] held_sum  = '0;
    logic         held_cout = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, ecnt, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sbq.delete();
            acc_edge  = -100;
            done_edge = -100;
            next_ok   = 0;
            held_sum  = '0;
            held_cout = 1'b0;
        end else begin
            ecnt++;
            if (ecnt == done_edge) begin
                held_sum  = pend_sum;
                held_cout = pend_cout;
            end
            if (ifc.start === 1'b1 && ecnt >= next_ok) begin
                {pend_cout, pend_sum} = {1'b0, ifc.op_a} + {1'b0, ifc.op_b};
                sbq.push_back('{s: pend_sum, c: pend_cout});
                acc_edge  = ecnt;
                done_edge = ecnt + W;
                next_ok   = ecnt + W + 2;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        logic exp_done;
        exp_busy = (ecnt >= acc_edge) && (ecnt <= acc_edge + W);
        exp_done = (ecnt == done_edge);
        chk("busy", 64'(ifc.busy), 64'(exp_busy));
        chk("done", 64'(ifc.done), 64'(exp_done));
        chk("sum_hold", 64'(ifc.sum), 64'(held_sum));
        chk("cout_hold", 64'(ifc.cout), 64'(held_cout));
        if (ifc.done === 1'b1) begin
            if (sbq.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL done_unexpected at edge %0d: got done=1 expected no pending result", ecnt);
            end else begin
                e = sbq.pop_front();
                chk("sum", 64'(ifc.sum), 64'(e.s));
                chk("cout", 64'(ifc.cout), 64'(e.c));
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            ifc.start = 1'b0;
            ifc.op_a  = W'($urandom);
            ifc.op_b  = W'($urandom);
        end
    endtask

    task automatic pulse(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        ifc.start = 1'b1;
        ifc.op_a  = a;
        ifc.op_b  = b;
    endtask

    initial begin
        rst       = 1'b1;
        ifc.start = 1'b0;
        ifc.op_a  = '0;
        ifc.op_b  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_sum", 64'(ifc.sum), 64'(0));
        chk("reset_busy", 64'(ifc.busy), 64'(0));

        // Quiet period: nothing may happen.
        idle(20);

        pulse(8'h35, 8'h4A);
        idle(12);
        pulse(8'hFF, 8'h01);
        idle(12);
        pulse(8'hFF, 8'hFF);
        idle(12);

        // Second start during an active addition is ignored.
        pulse(8'h12, 8'h34);
        idle(2);
        pulse(8'hAA, 8'hAA);
        idle(12);

        // Reset in the middle of an addition, then a fresh one.
        pulse(8'hC3, 8'h5A);
        idle(3);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(ifc.busy), 64'(0));
        chk("midrst_sum", 64'(ifc.sum), 64'(0));
        chk("midrst_cout", 64'(ifc.cout), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        pulse(8'h9C, 8'h81);
        idle(12);

        // Start held high: a new addition each time IDLE is re-entered.
        @(posedge clk);
        #1;
        ifc.start = 1'b1;
        ifc.op_a  = 8'h10;
        ifc.op_b  = 8'h20;
        repeat (45) @(posedge clk);
        #1;
        idle(12);

        // Random start activity with operands changing every cycle.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            ifc.start = 1'($urandom_range(0, 2) == 0);
            ifc.op_a  = W'($urandom);
            ifc.op_b  = W'($urandom);
        end
        idle(15);

        chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial addition sequencer that wraps the team's 1-bit add cell. It accepts two WIDTH-bit operands on a start pulse and presents them LSB-first, one bit per clock, to an internal 1-bit full-add datapath with a registered carry. It assembles the serial sum bits into a parallel result and signals completion with a one-cycle done pulse. It is the upstream feed and downstream collector for the single-bit adder, which lets that cell handle multi-bit words.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 2 to 32.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- start  input  1  request pulse; sampled only in IDLE.
- op_a  input  WIDTH  first operand; captured on an accepted start.
- op_b  input  WIDTH  second operand; captured on an accepted start.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result (op_a + op_b) mod 2^WIDTH.
- cout  output  1  registered carry-out of the MSB.

## Operation
- Internal state:
  - Shift registers sa and sb (WIDTH bits each).
  - Partial-sum shift register ps (WIDTH bits).
  - Carry flop cy.
  - Bit counter cnt, width clog2(WIDTH+1).
  - 2-bit FSM.
- FSM states:
  - IDLE:
    - If start=1: capture sa<=op_a, sb<=op_b, cy<=0, cnt<=0, ps<=0, then go to SHIFT.
    - Otherwise hold.
  - SHIFT, each cycle:
    - Compute s = sa[0]^sb[0]^cy and cy <= majority(sa[0], sb[0], cy).
    - ps <= {s, ps[WIDTH-1:1]}; sa and sb shift right with zero fill; cnt <= cnt+1.
    - On the cycle where cnt==WIDTH-1 (the last bit): load sum <= {s, ps[WIDTH-1:1]} and cout <= carry-out of that bit, then go to DONE.
  - DONE: done=1 for this single cycle, then go unconditionally to IDLE.
- start is ignored in SHIFT and DONE; operands are not re-captured.
- sum and cout change only when entering DONE; they hold their values through IDLE until the next completion.
- op_a and op_b are don't-care except on the accepted start edge.
- Arithmetic is unsigned. Overflow appears only on cout; sum wraps mod 2^WIDTH.

## Timing
- Reset values:
  - FSM=IDLE, busy=0, done=0, sum=0, cout=0.
  - sa, sb, ps, cy and cnt = 0.
- Reset asserted mid-operation aborts the addition immediately. No done pulse follows, and sum/cout go to 0.
- Latency: start sampled at edge E0, then SHIFT occupies edges E1..EWIDTH. done is high in the cycle after edge EWIDTH (WIDTH+1 clocks after E0). WIDTH=8 gives done 9 cycles after start.
- busy rises the cycle after E0 and falls together with done.
- Minimum start-to-start spacing is WIDTH+2 cycles. A start asserted in the cycle done is high is ignored; a start in the next cycle (IDLE) is accepted.
- A start held high continuously restarts an addition each time IDLE is entered.

## Test plan
- WIDTH=8, op_a=8'h35, op_b=8'h4A, 1-cycle start -> done exactly 9 cycles later, sum=8'h7F, cout=0, busy high for 9 cycles.
- op_a=8'hFF, op_b=8'h01 -> sum=8'h00, cout=1; then op_a=8'hFF, op_b=8'hFF -> sum=8'hFE, cout=1.
- Start pulsed again at cycle 3 of an active addition with different operands -> ignored; the first result is unchanged and exactly one done pulse occurs.
- Assert rst at cycle 4 of an addition -> busy=0, sum=0, cout=0 immediately; no done pulse. A fresh start after release gives a correct result.
- Start held high continuously with 8'h10+8'h20 -> done pulses every 10 cycles, each with sum=8'h30, cout=0; sum is stable between pulses.
- Reset with no activity -> all outputs 0; start=0 for 20 cycles -> busy and done stay 0.
